// File: rtl/ni_router_input_port.sv
// Router input port: 8-flit FIFO fed by an upstream sensor NI, XY route
// computation on head flits, and a registered valid/ready offer to the crossbar.
module ni_router_input_port #(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned BUSY_LEVEL = 6
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  core_address,
   input  logic        in_req,
   input  logic [15:0] in_data,
   output logic        in_bussy,
   output logic        out_valid,
   output logic [15:0] out_data,
   output logic [4:0]  out_port,
   input  logic        out_ready,
   output logic [7:0]  err_cnt,
   output logic        ovf_err
);

   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned FLIT_W = 16;
   localparam int unsigned PORT_W = 5;

   typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;

   state_t              state, state_d;
   logic [PORT_W-1:0]   route, route_d;
   logic                first, first_d;
   logic                pop, err_inc, wr, run, empty, full;
   logic [FLIT_W-1:0]   mem [FIFO_DEPTH];
   logic [FLIT_W-1:0]   top, top_d;
   logic [PTR_W-1:0]    wr_ptr, rd_ptr, rd_ptr_d;
   logic [CNT_W-1:0]    count, count_d, remain;
   logic                valid_d;
   logic [1:0]          rst_sync;

   // XY routing: resolve X first, then Y, else deliver locally
   function automatic logic [PORT_W-1:0] xy_route(input logic [FLIT_W-1:0] f,
                                                  input logic [3:0] addr);
      logic [1:0] dx, dy, lx, ly;
      dx = f[12:11];
      dy = f[10:9];
      lx = addr[3:2];
      ly = addr[1:0];
      if (dx > lx)      return PORT_W'(5'b00010);
      else if (dx < lx) return PORT_W'(5'b00100);
      else if (dy > ly) return PORT_W'(5'b01000);
      else if (dy < ly) return PORT_W'(5'b10000);
      else              return PORT_W'(5'b00001);
   endfunction

   // Reset release is retimed so no write or pop happens on the release edge
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) rst_sync <= 2'b00;
      else        rst_sync <= {rst_sync[0], 1'b1};
   end

   assign run   = rst_sync[1];
   assign top   = mem[rd_ptr];
   assign empty = (count == '0);
   assign full  = (count == CNT_W'(FIFO_DEPTH));
   assign wr    = run && in_req && !full;

   // FSM next state: route latch on head, discard stray bodies, detect truncation
   always_comb begin
      state_d = state;
      route_d = route;
      first_d = first;
      pop     = 1'b0;
      err_inc = 1'b0;
      case (state)
         IDLE: begin
            if (run && !empty) begin
               if (top[15]) begin
                  route_d = xy_route(top, core_address);
                  first_d = 1'b1;
                  state_d = SEND;
               end else begin
                  pop     = 1'b1;
                  err_inc = 1'b1;
               end
            end
         end
         SEND: begin
            if (out_valid && out_ready) begin
               pop     = 1'b1;
               first_d = 1'b0;
               if (top[13]) state_d = IDLE;
            end else if (!empty && top[15] && !first) begin
               state_d = IDLE;
               err_inc = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Look ahead to next-cycle FIFO top so the registered offer streams 1 flit/cycle
   always_comb begin
      count_d  = count + CNT_W'(wr) - CNT_W'(pop);
      rd_ptr_d = rd_ptr + PTR_W'(pop);
      remain   = count - CNT_W'(pop);
      top_d    = (remain == '0) ? in_data : mem[rd_ptr_d];
      valid_d  = run && (state == SEND) && (state_d == SEND) && (count_d != '0)
                 && !(top_d[15] && !first_d);
   end

   // FSM and route registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         route <= '0;
         first <= 1'b0;
      end else begin
         state <= state_d;
         route <= route_d;
         first <= first_d;
      end
   end

   // FIFO storage; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (wr) mem[wr_ptr] <= in_data;
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + PTR_W'(wr);
         rd_ptr <= rd_ptr_d;
         count  <= count_d;
      end
   end

   // Error counter (saturating) and sticky overflow flag
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_cnt <= '0;
         ovf_err <= 1'b0;
      end else begin
         if (err_inc && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
         if (run && in_req && full)         ovf_err <= 1'b1;
      end
   end

   // Registered outputs toward upstream NI and crossbar
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         in_bussy  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_port  <= '0;
      end else begin
         in_bussy  <= (count_d >= CNT_W'(BUSY_LEVEL));
         out_valid <= valid_d;
         out_data  <= valid_d ? top_d : '0;
         out_port  <= valid_d ? route : '0;
      end
   end

endmodule

// File: tb/tb_ni_router_input_port.sv
// Scoreboard bench for ni_router_input_port: directed flits, expected
// {data, port} queued at issue time, compared by a negedge monitor on handshake.
module tb_ni_router_input_port;

   logic        clk;
   logic        reset;
   logic [3:0]  core_address;
   logic        in_req;
   logic [15:0] in_data;
   logic        in_bussy;
   logic        out_valid;
   logic [15:0] out_data;
   logic [4:0]  out_port;
   logic        out_ready;
   logic [7:0]  err_cnt;
   logic        ovf_err;

   int checks   = 0;
   int failures = 0;
   logic [20:0] exp_q[$];
   int  hs_run = 0;
   int  hs_max = 0;
   bit  prev_hs = 0;

   localparam logic [4:0] P_L = 5'b00001, P_E = 5'b00010, P_W = 5'b00100,
                          P_N = 5'b01000, P_S = 5'b10000;

   ni_router_input_port #(.FIFO_DEPTH(8), .BUSY_LEVEL(6)) dut (
      .clk(clk), .reset(reset), .core_address(core_address),
      .in_req(in_req), .in_data(in_data), .in_bussy(in_bussy),
      .out_valid(out_valid), .out_data(out_data), .out_port(out_port),
      .out_ready(out_ready), .err_cnt(err_cnt), .ovf_err(ovf_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Drive one flit for one clock; returns 1 time unit after that edge
   task automatic drive(input logic [15:0] d);
      in_req  = 1'b1;
      in_data = d;
      @(posedge clk); #1;
      in_req  = 1'b0;
      in_data = 16'h0;
   endtask

   task automatic expect_flit(input logic [15:0] d, input logic [4:0] p);
      exp_q.push_back({d, p});
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      repeat (4) @(posedge clk);
      #1;
      chk(name, 32'(exp_q.size()), 32'd0);
   endtask

   // Monitor: pop and compare on every handshake, and idle port must be zero
   always @(negedge clk) begin
      if (reset) begin
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_flit actual=%0h/%0b expected=none", out_data, out_port);
            end else begin
               logic [20:0] e;
               e = exp_q.pop_front();
               chk("flit_data", 32'(out_data), 32'(e[20:5]));
               chk("flit_port", 32'(out_port), 32'(e[4:0]));
            end
            hs_run = prev_hs ? hs_run + 1 : 1;
            if (hs_run > hs_max) hs_max = hs_run;
            prev_hs = 1'b1;
         end else begin
            prev_hs = 1'b0;
         end
         if (!out_valid) chk("idle_port_zero", 32'(out_port), 32'd0);
      end
   end

   initial begin
      int vcnt;
      reset = 1'b0; in_req = 1'b0; in_data = 16'h0;
      out_ready = 1'b1; core_address = 4'b0000;

      // Reset state
      #12;
      chk("rst_bussy", 32'(in_bussy), 0);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_port", 32'(out_port), 0);
      chk("rst_data", 32'(out_data), 0);
      chk("rst_err", 32'(err_cnt), 0);
      chk("rst_ovf", 32'(ovf_err), 0);
      @(negedge clk); reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      // Single flit to East with latency check
      core_address = 4'b0101;
      expect_flit(16'hB200, P_E);
      drive(16'hB200);
      chk("lat_n0", 32'(out_valid), 0);
      @(posedge clk); #1;
      chk("lat_n1", 32'(out_valid), 0);
      @(posedge clk); #1;
      chk("lat_n2", 32'(out_valid), 1);
      drain("drain_east");
      chk("east_idle_valid", 32'(out_valid), 0);

      // 3-flit packet to North, back-to-back
      hs_max = 0;
      expect_flit(16'h8C00, P_N);
      expect_flit(16'h0011, P_N);
      expect_flit(16'h2022, P_N);
      drive(16'h8C00); drive(16'h0011); drive(16'h2022);
      drain("drain_north");
      chk("north_streak", 32'(hs_max), 3);

      // West and South singles
      expect_flit(16'hA000, P_W);
      drive(16'hA000);
      drain("drain_west");
      expect_flit(16'hA800, P_S);
      drive(16'hA800);
      drain("drain_south");

      // Overflow: 9 flits with crossbar stalled
      core_address = 4'b0000;
      out_ready = 1'b0;
      drive(16'h8000);
      for (int i = 1; i <= 6; i++) begin
         drive(16'h0100 + 16'(i));
         if (i == 4) chk("bussy_at5", 32'(in_bussy), 0);
         if (i == 5) chk("bussy_at6", 32'(in_bussy), 1);
      end
      drive(16'h2107);
      chk("ovf_before", 32'(ovf_err), 0);
      drive(16'h2FFF);
      chk("ovf_after", 32'(ovf_err), 1);
      chk("ovf_err_cnt", 32'(err_cnt), 0);
      chk("stall_valid", 32'(out_valid), 1);
      chk("stall_data", 32'(out_data), 32'h8000);
      chk("stall_port", 32'(out_port), 32'(P_L));
      @(posedge clk); #1;
      chk("stall_data_hold", 32'(out_data), 32'h8000);
      expect_flit(16'h8000, P_L);
      for (int i = 1; i <= 6; i++) expect_flit(16'h0100 + 16'(i), P_L);
      expect_flit(16'h2107, P_L);
      out_ready = 1'b1;
      drain("drain_ovf");
      chk("ovf_sticky", 32'(ovf_err), 1);
      chk("bussy_drained", 32'(in_bussy), 0);

      // Stray body flit in IDLE
      vcnt = 0;
      drive(16'h0001);
      for (int i = 0; i < 6; i++) begin
         if (out_valid) vcnt++;
         @(posedge clk); #1;
      end
      chk("stray_no_valid", 32'(vcnt), 0);
      chk("stray_err", 32'(err_cnt), 1);

      // Truncated packet followed by a new head
      expect_flit(16'h8000, P_L);
      expect_flit(16'hA000, P_L);
      drive(16'h8000); drive(16'hA000);
      drain("drain_trunc");
      chk("trunc_err", 32'(err_cnt), 2);

      // Reset mid-packet with 4 flits buffered
      out_ready = 1'b0;
      drive(16'h8000); drive(16'h0101); drive(16'h0102); drive(16'h0103);
      repeat (2) @(posedge clk);
      #3;
      reset = 1'b0;
      exp_q.delete();
      #1;
      chk("mid_rst_valid", 32'(out_valid), 0);
      chk("mid_rst_data", 32'(out_data), 0);
      chk("mid_rst_port", 32'(out_port), 0);
      chk("mid_rst_bussy", 32'(in_bussy), 0);
      chk("mid_rst_err", 32'(err_cnt), 0);
      chk("mid_rst_ovf", 32'(ovf_err), 0);
      out_ready = 1'b1;
      @(negedge clk); reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("post_rst_valid", 32'(out_valid), 0);
      chk("post_rst_err", 32'(err_cnt), 0);
      expect_flit(16'hA000, P_L);
      drive(16'hA000);
      drain("drain_post_rst");
      chk("post_rst_err2", 32'(err_cnt), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
